video_frame_rx: RTL and testbench
=================================

// Module: video_frame_rx
// PURPOSE
//  Receiving end of the pixel-stream interface: consumes a valid/ready pixel stream with a start-of-frame flag.
//  Regenerates each accepted pixel's (hcount, vcount), checks framing and re-locks after corruption.
//  Sits between the video source FIFO and the VGA output/overlay stages.
//  Downstream stages get pixel coordinates and line/frame markers without their own counters.
// PARAMETERS
//  HMAX  640  active pixels per line; hcount wraps at HMAX-1
//  VMAX  480  active lines per frame; vcount wraps at VMAX-1
//  DW    12   pixel data width (bits)
//  ERRW  16   width of framing-error and good-frame counters
// PORTS
//  clk          in   1     system clock
//  reset_n      in   1     asynchronous reset, active-low
//  sync_clr     in   1     synchronous clear: force SEEK, zero counters, drop held output beat
//  s_data       in   DW    input pixel
//  s_valid      in   1     input beat valid
//  s_sof        in   1     input beat is pixel (0,0)
//  s_ready      out  1     input beat accepted when s_valid & s_ready
//  m_data       out  DW    output pixel
//  m_valid      out  1     output beat valid
//  m_ready      in   1     downstream accepts when m_valid & m_ready
//  m_hcount     out  11    column of output beat
//  m_vcount     out  11    row of output beat
//  m_sof        out  1     output beat is (0,0)
//  m_eol        out  1     output beat is column HMAX-1
//  m_eof        out  1     output beat is (HMAX-1, VMAX-1)
//  locked       out  1     1 in LOCKED state
//  err_pulse    out  1     one-cycle pulse per framing error
//  err_count    out  ERRW  saturating framing-error count
//  frame_count  out  ERRW  wrapping count of error-free completed frames
// BEHAVIOUR
//  - Async reset (reset_n=0): state SEEK; hc=vc=0; m_valid=0; m_data, m_hcount, m_vcount=0; all flags 0; counters 0.
//  - Priority: reset_n > sync_clr > normal operation. sync_clr does NOT clear err_count/frame_count.
//  - Output stage: one register slice.
//    - s_ready = ~m_valid | m_ready, in both states. Combinational from m_ready; no bubble under full throughput.
//    - Latency: accepted beat appears on m_* the next cycle.
//    - m_* are held stable while m_valid & ~m_ready.
//  - Position counters hc/vc give the expected position of the next input beat.
//    - Advance only on an accepted beat that is forwarded.
//    - hc wraps HMAX-1 -> 0 and then increments vc; vc wraps VMAX-1 -> 0.
//  - SEEK state:
//    - Accepted beat with s_sof=0: dropped; no output, no error.
//    - Accepted beat with s_sof=1: forwarded as (0,0); hc=1, vc=0; go LOCKED.
//  - LOCKED state, on an accepted beat:
//    - s_sof matches (hc,vc)==(0,0): forward with current coordinates.
//    - s_sof=1 at (hc,vc)!=(0,0) (early SOF): err_pulse; forward as (0,0); hc=1, vc=0; stay LOCKED.
//      The truncated frame is not counted.
//    - s_sof=0 at (0,0) (missing SOF): err_pulse; drop beat; zero counters; go SEEK.
//  - m_sof/m_eol/m_eof decode from the forwarded coordinates, registered together with m_data.
//  - frame_count increments when an m_eof beat is forwarded and no error occurred since its SOF.
//  - err_count saturates at all-ones. err_pulse and the counter update happen in the cycle after the offending accept.
//  - Idle input (s_valid=0) or stalled output: counters and state hold.
// CONFIGURATION
//  - FRAME_RX_STATS_EN defined:
//    - err_count and frame_count are implemented as above.
//  - Not defined:
//    - err_count and frame_count are tied to 0 and no counter registers exist.
//    - err_pulse, locked and all framing behaviour are unchanged.
// TESTING
//  1. Reset, then HMAX=4, VMAX=2, continuous valid with SOF on beat 0, m_ready=1.
//     -> locked=1 after the first accept.
//     -> coords (0,0)..(3,1); m_eol on beats 3 and 7; m_eof on beat 7; frame_count=1.
//  2. Three non-SOF beats before the first SOF.
//     -> No m_valid for those beats; the SOF beat is output as (0,0); err_count stays 0.
//  3. While LOCKED at (2,1), inject a SOF beat.
//     -> err_pulse=1 for one cycle; the beat is output as (0,0); err_count=1; frame_count unchanged.
//  4. Non-SOF beat at expected (0,0).
//     -> Beat dropped; locked=0; err_count+1; the next SOF beat relocks at (0,0).
//  5. m_ready=0 for 5 cycles mid-line.
//     -> s_ready=0 after one beat is held; m_data/m_hcount stable; no beats lost or duplicated on release.
//  6. Assert sync_clr and reset_n=0 mid-frame.
//     -> sync_clr: SEEK, m_valid=0, counters kept.
//     -> reset_n: all outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/video_frame_rx.sv
// video_frame_rx: receive side of a valid/ready pixel stream with a
// start-of-frame flag. Regenerates (hcount, vcount) for every forwarded
// pixel, checks framing against the expected position and re-locks on the
// next SOF after a missing-SOF error. A single register slice drives m_*.
// Optional build macro FRAME_RX_STATS_EN adds the error/good-frame counters;
// without it err_count and frame_count are constant zero.
//
// Handshake: a beat transfers on any rising clk edge where valid & ready are
// both high; a source holds its beat (data and flags) stable until then, and
// ready may depend combinationally on the other side's ready.
module video_frame_rx #(
  parameter int HMAX = 640,
  parameter int VMAX = 480,
  parameter int DW   = 12,
  parameter int ERRW = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            sync_clr,
  input  logic [DW-1:0]   s_data,
  input  logic            s_valid,
  input  logic            s_sof,
  output logic            s_ready,
  output logic [DW-1:0]   m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [10:0]     m_hcount,
  output logic [10:0]     m_vcount,
  output logic            m_sof,
  output logic            m_eol,
  output logic            m_eof,
  output logic            locked,
  output logic            err_pulse,
  output logic [ERRW-1:0] err_count,
  output logic [ERRW-1:0] frame_count
);

  typedef enum logic {
    SEEK   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [10:0] HLAST = 11'(HMAX - 1);
  localparam logic [10:0] VLAST = 11'(VMAX - 1);

  state_e      state_q, state_d;
  logic [10:0] hc_q, hc_d;
  logic [10:0] vc_q, vc_d;

  logic          m_valid_q;
  logic [DW-1:0] m_data_q;
  logic [10:0]   m_hcount_q, m_vcount_q;
  logic          m_sof_q, m_eol_q, m_eof_q;
  logic          err_pulse_q;

  logic        accept;
  logic        at_origin;
  logic        fwd;
  logic        err;
  logic [10:0] fwd_h, fwd_v;
  logic        sof_d, eol_d, eof_d;

  // The slice can take a new beat whenever it is empty or being drained.
  assign s_ready   = ~m_valid_q | m_ready;
  assign accept    = s_valid & s_ready;
  assign at_origin = (hc_q == 11'd0) && (vc_q == 11'd0);

  // Framing decision for the accepted beat and next expected position.
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    vc_d    = vc_q;
    fwd     = 1'b0;
    err     = 1'b0;
    fwd_h   = hc_q;
    fwd_v   = vc_q;
    if (accept) begin
      case (state_q)
        SEEK: begin
          if (s_sof) begin
            fwd     = 1'b1;
            fwd_h   = 11'd0;
            fwd_v   = 11'd0;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (s_sof && !at_origin) begin
            // Early SOF: restart the frame at the new SOF.
            err   = 1'b1;
            fwd   = 1'b1;
            fwd_h = 11'd0;
            fwd_v = 11'd0;
          end else if (!s_sof && at_origin) begin
            // Missing SOF: drop the beat and hunt for the next SOF.
            err     = 1'b1;
            state_d = SEEK;
            hc_d    = 11'd0;
            vc_d    = 11'd0;
          end else begin
            fwd = 1'b1;
          end
        end
        default: state_d = SEEK;
      endcase
    end
    if (fwd) begin
      if (fwd_h == HLAST) begin
        hc_d = 11'd0;
        vc_d = (fwd_v == VLAST) ? 11'd0 : fwd_v + 11'd1;
      end else begin
        hc_d = fwd_h + 11'd1;
        vc_d = fwd_v;
      end
    end
  end

  assign sof_d = (fwd_h == 11'd0) && (fwd_v == 11'd0);
  assign eol_d = (fwd_h == HLAST);
  assign eof_d = eol_d && (fwd_v == VLAST);

  // State, position counters and the output register slice.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SEEK;
      hc_q        <= 11'd0;
      vc_q        <= 11'd0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_hcount_q  <= 11'd0;
      m_vcount_q  <= 11'd0;
      m_sof_q     <= 1'b0;
      m_eol_q     <= 1'b0;
      m_eof_q     <= 1'b0;
      err_pulse_q <= 1'b0;
    end else if (sync_clr) begin
      state_q     <= SEEK;
      hc_q        <= 11'd0;
      vc_q        <= 11'd0;
      m_valid_q   <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      err_pulse_q <= err;
      if (s_ready) begin
        m_valid_q <= fwd;
        if (fwd) begin
          m_data_q   <= s_data;
          m_hcount_q <= fwd_h;
          m_vcount_q <= fwd_v;
          m_sof_q    <= sof_d;
          m_eol_q    <= eol_d;
          m_eof_q    <= eof_d;
        end
      end
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_hcount  = m_hcount_q;
  assign m_vcount  = m_vcount_q;
  assign m_sof     = m_sof_q;
  assign m_eol     = m_eol_q;
  assign m_eof     = m_eof_q;
  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;

`ifdef FRAME_RX_STATS_EN
  logic [ERRW-1:0] err_count_q;
  logic [ERRW-1:0] frame_count_q;

  // Every forwarded frame begins at a (re)lock SOF and any framing error
  // either restarts the frame or drops lock, so a forwarded EOF always
  // closes an error-free frame. sync_clr leaves both counters alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count_q   <= '0;
      frame_count_q <= '0;
    end else if (!sync_clr) begin
      if (err && !(&err_count_q)) begin
        err_count_q <= err_count_q + ERRW'(1);
      end
      if (fwd && eof_d) begin
        frame_count_q <= frame_count_q + ERRW'(1);
      end
    end
  end

  assign err_count   = err_count_q;
  assign frame_count = frame_count_q;
`else
  assign err_count   = '0;
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_video_frame_rx.sv
// Bench for video_frame_rx with a 4x2 frame. A negedge scoreboard runs a
// pixel-index reference model (expected position as a linear index) with an
// expected queue of output beats; directed tasks add scenario checks.
module tb_video_frame_rx;
  localparam int HMAX = 4;
  localparam int VMAX = 2;
  localparam int DW   = 12;
  localparam int ERRW = 16;
  localparam int NPIX = HMAX * VMAX;
  localparam int W    = DW + 25;
`ifdef FRAME_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sync_clr = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_valid = 1'b0;
  logic s_sof = 1'b0;
  logic s_ready;
  logic [DW-1:0] m_data;
  logic m_valid;
  logic m_ready = 1'b0;
  logic [10:0] m_hcount, m_vcount;
  logic m_sof, m_eol, m_eof, locked, err_pulse;
  logic [ERRW-1:0] err_count, frame_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit sb_en   = 1'b0;

  video_frame_rx #(.HMAX(HMAX), .VMAX(VMAX), .DW(DW), .ERRW(ERRW)) dut (
    .clk(clk), .reset_n(reset_n), .sync_clr(sync_clr),
    .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_hcount(m_hcount), .m_vcount(m_vcount),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .frame_count(frame_count)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Reference model: expected output queue, lock flag, position index
  logic [W-1:0] exp_q[$];
  int exp_pos = 0;
  bit exp_locked = 1'b0;
  bit exp_err = 1'b0;
  int exp_err_cnt = 0;
  int exp_frame_cnt = 0;

  function automatic logic [W-1:0] beat_word(input logic [DW-1:0] d, input int idx);
    int h;
    int v;
    h = idx % HMAX;
    v = idx / HMAX;
    return {d, 11'(h), 11'(v), (idx == 0), (h == HMAX - 1), (idx == NPIX - 1)};
  endfunction

  // Scoreboard: compare registered outputs, then advance the model
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic exp_rdy;
    bit acc;
    int fwd;
    if (sb_en) begin
      if (reset_n !== 1'b1) begin
        exp_q.delete();
        exp_pos = 0; exp_locked = 0; exp_err = 0;
        exp_err_cnt = 0; exp_frame_cnt = 0;
      end
      n_tests++;
      if (m_valid !== (exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL sb_m_valid t=%0t: got %b want %b", $time, m_valid, exp_q.size() != 0);
      end
      if (m_valid === 1'b1 && exp_q.size() != 0) begin
        n_tests++;
        got = {m_data, m_hcount, m_vcount, m_sof, m_eol, m_eof};
        if (got !== exp_q[0]) begin
          n_fail++;
          $display("FAIL sb_beat t=%0t: got %h want %h", $time, got, exp_q[0]);
        end
      end
      n_tests++;
      if (locked !== exp_locked) begin
        n_fail++;
        $display("FAIL sb_locked t=%0t: got %b want %b", $time, locked, exp_locked);
      end
      n_tests++;
      if (err_pulse !== exp_err) begin
        n_fail++;
        $display("FAIL sb_err_pulse t=%0t: got %b want %b", $time, err_pulse, exp_err);
      end
      exp_rdy = (exp_q.size() == 0) || (m_ready === 1'b1);
      n_tests++;
      if (s_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL sb_s_ready t=%0t: got %b want %b", $time, s_ready, exp_rdy);
      end
      n_tests++;
      if (err_count !== ERRW'(STATS ? exp_err_cnt : 0)) begin
        n_fail++;
        $display("FAIL sb_err_count t=%0t: got %0d want %0d", $time, err_count, STATS ? exp_err_cnt : 0);
      end
      n_tests++;
      if (frame_count !== ERRW'(STATS ? exp_frame_cnt : 0)) begin
        n_fail++;
        $display("FAIL sb_frame_count t=%0t: got %0d want %0d", $time, frame_count, STATS ? exp_frame_cnt : 0);
      end
      // model step for the coming edge
      if (reset_n !== 1'b1) begin
        exp_err = 0;
      end else if (sync_clr === 1'b1) begin
        exp_q.delete();
        exp_pos = 0; exp_locked = 0; exp_err = 0;
      end else begin
        acc = (s_valid === 1'b1) && exp_rdy;
        if (m_ready === 1'b1 && exp_q.size() != 0) void'(exp_q.pop_front());
        exp_err = 0;
        if (acc) begin
          fwd = -1;
          if (!exp_locked) begin
            if (s_sof === 1'b1) begin fwd = 0; exp_locked = 1; end
          end else if (s_sof === 1'b1 && exp_pos != 0) begin
            exp_err = 1; fwd = 0;
          end else if (s_sof !== 1'b1 && exp_pos == 0) begin
            exp_err = 1; exp_locked = 0;
          end else begin
            fwd = exp_pos;
          end
          if (fwd >= 0) begin
            exp_q.push_back(beat_word(s_data, fwd));
            exp_pos = (fwd + 1) % NPIX;
            if (fwd == NPIX - 1) exp_frame_cnt = (exp_frame_cnt + 1) % 65536;
          end
          if (exp_err && exp_err_cnt < 65535) exp_err_cnt++;
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit sof, input logic [DW-1:0] d);
    s_valid = v;
    s_sof   = sof;
    s_data  = d;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, 0, '0);
    m_ready = 1'b0;
    tick();
    sb_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({m_valid, m_sof, m_eol, m_eof, locked, err_pulse} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_flags: got %b want 000000", {m_valid, m_sof, m_eol, m_eof, locked, err_pulse});
      end
      n_tests++;
      if ({m_data, m_hcount, m_vcount} !== '0) begin
        n_fail++;
        $display("FAIL reset_data_coords: got %h/%0d/%0d want 0/0/0", m_data, m_hcount, m_vcount);
      end
      n_tests++;
      if ({err_count, frame_count} !== '0) begin
        n_fail++;
        $display("FAIL reset_counters: got %0d/%0d want 0/0", err_count, frame_count);
      end
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    int eol_n = 0;
    int eof_n = 0;
    m_ready = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      drive(1, i == 0, DW'($urandom_range(0, 4095)));
      tick();
      if (i == 0) begin
        n_tests++;
        if (locked !== 1'b1) begin
          n_fail++;
          $display("FAIL basic_locked: got %b want 1", locked);
        end
      end
      if (m_valid === 1'b1 && m_eol === 1'b1) eol_n++;
      if (m_valid === 1'b1 && m_eof === 1'b1) eof_n++;
    end
    n_tests++;
    if ({m_hcount, m_vcount} !== {11'd3, 11'd1}) begin
      n_fail++;
      $display("FAIL basic_last_coord: got (%0d,%0d) want (3,1)", m_hcount, m_vcount);
    end
    drive(0, 0, '0);
    tick();
    n_tests++;
    if (eol_n != 2 || eof_n != 1) begin
      n_fail++;
      $display("FAIL basic_eol_eof: got eol=%0d eof=%0d want 2/1", eol_n, eof_n);
    end
    n_tests++;
    if (frame_count !== ERRW'(STATS ? 1 : 0)) begin
      n_fail++;
      $display("FAIL basic_frame_count: got %0d want %0d", frame_count, STATS ? 1 : 0);
    end
  endtask

  task automatic test_seek_drop();
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    n_tests++;
    if ({locked, m_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL seek_after_clr: got locked=%b m_valid=%b want 0/0", locked, m_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, DW'($urandom_range(0, 4095)));
      tick();
      n_tests++;
      if (m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL seek_drop_%0d: got m_valid=%b want 0", i, m_valid);
      end
    end
    drive(1, 1, 12'h5a5);
    tick();
    n_tests++;
    if ({m_valid, m_sof, m_hcount, m_vcount, m_data} !== {1'b1, 1'b1, 11'd0, 11'd0, 12'h5a5}) begin
      n_fail++;
      $display("FAIL seek_sof_out: got v=%b sof=%b (%0d,%0d) %h want 1 1 (0,0) 5a5",
               m_valid, m_sof, m_hcount, m_vcount, m_data);
    end
    n_tests++;
    if (err_count !== '0) begin
      n_fail++;
      $display("FAIL seek_err_count: got %0d want 0", err_count);
    end
  endtask

  task automatic test_early_sof();
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, DW'($urandom_range(0, 4095)));
      tick();
    end
    drive(1, 1, 12'h3c3);
    tick();
    n_tests++;
    if ({err_pulse, m_valid, m_sof, m_hcount, m_vcount} !== {1'b1, 1'b1, 1'b1, 11'd0, 11'd0}) begin
      n_fail++;
      $display("FAIL early_sof_out: got err=%b v=%b sof=%b (%0d,%0d) want 1 1 1 (0,0)",
               err_pulse, m_valid, m_sof, m_hcount, m_vcount);
    end
    n_tests++;
    if ({err_count, frame_count} !== {ERRW'(STATS ? 1 : 0), ERRW'(STATS ? 1 : 0)}) begin
      n_fail++;
      $display("FAIL early_sof_counts: got %0d/%0d want %0d/%0d", err_count, frame_count,
               STATS ? 1 : 0, STATS ? 1 : 0);
    end
    drive(0, 0, '0);
    tick();
    n_tests++;
    if (err_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL early_sof_pulse_len: got %b want 0", err_pulse);
    end
  endtask

  task automatic test_missing_sof();
    for (int i = 1; i < NPIX; i++) begin
      drive(1, 0, DW'($urandom_range(0, 4095)));
      tick();
    end
    drive(1, 0, 12'h111);
    tick();
    n_tests++;
    if ({locked, m_valid, err_pulse} !== 3'b001) begin
      n_fail++;
      $display("FAIL missing_sof_drop: got locked=%b v=%b err=%b want 0 0 1", locked, m_valid, err_pulse);
    end
    n_tests++;
    if ({err_count, frame_count} !== {ERRW'(STATS ? 2 : 0), ERRW'(STATS ? 2 : 0)}) begin
      n_fail++;
      $display("FAIL missing_sof_counts: got %0d/%0d want %0d/%0d", err_count, frame_count,
               STATS ? 2 : 0, STATS ? 2 : 0);
    end
    drive(1, 1, 12'h222);
    tick();
    n_tests++;
    if ({locked, m_valid, m_sof, m_hcount, m_vcount} !== {3'b111, 11'd0, 11'd0}) begin
      n_fail++;
      $display("FAIL missing_sof_relock: got locked=%b v=%b sof=%b (%0d,%0d) want 1 1 1 (0,0)",
               locked, m_valid, m_sof, m_hcount, m_vcount);
    end
  endtask

  task automatic test_stall();
    drive(1, 0, 12'habc);
    tick();
    m_ready = 1'b0;
    drive(1, 0, 12'hdef);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({s_ready, m_valid, m_data, m_hcount} !== {1'b0, 1'b1, 12'habc, 11'd1}) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got rdy=%b v=%b %h h=%0d want 0 1 abc 1",
                 i, s_ready, m_valid, m_data, m_hcount);
      end
    end
    m_ready = 1'b1;
    tick();
    n_tests++;
    if ({m_valid, m_data, m_hcount} !== {1'b1, 12'hdef, 11'd2}) begin
      n_fail++;
      $display("FAIL stall_release: got v=%b %h h=%0d want 1 def 2", m_valid, m_data, m_hcount);
    end
    drive(0, 0, '0);
    tick();
  endtask

  task automatic test_random();
    int src_pos = 0;
    bit take;
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) < 7, 0, DW'($urandom_range(0, 4095)));
      s_sof = (src_pos == 0);
      if ($urandom_range(0, 59) == 0) s_sof = ~s_sof;
      m_ready  = ($urandom_range(0, 3) != 0);
      sync_clr = ($urandom_range(0, 299) == 0);
      #1;
      take = (s_valid === 1'b1) && (s_ready === 1'b1);
      tick();
      if (take) src_pos = (src_pos + 1) % NPIX;
    end
    drive(0, 0, '0);
    sync_clr = 1'b0;
    m_ready = 1'b1;
    tick();
    tick();
    n_tests++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: got m_valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_clear_and_reset();
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, i == 0, DW'($urandom_range(0, 4095)));
      tick();
    end
    m_ready = 1'b0;
    drive(0, 0, '0);
    tick();
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    n_tests++;
    if ({locked, m_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL sync_clr_state: got locked=%b v=%b want 0 0", locked, m_valid);
    end
    n_tests++;
    if ({err_count, frame_count} !== {ERRW'(STATS ? exp_err_cnt : 0), ERRW'(STATS ? exp_frame_cnt : 0)}) begin
      n_fail++;
      $display("FAIL sync_clr_counts: got %0d/%0d want %0d/%0d", err_count, frame_count,
               STATS ? exp_err_cnt : 0, STATS ? exp_frame_cnt : 0);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, i == 0, DW'($urandom_range(1, 4095)));
      tick();
    end
    drive(0, 0, '0);
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({m_valid, m_sof, m_eol, m_eof, locked, err_pulse, m_data, m_hcount, m_vcount} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got v=%b locked=%b %h (%0d,%0d) want all 0",
               m_valid, locked, m_data, m_hcount, m_vcount);
    end
    n_tests++;
    if ({err_count, frame_count} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_counts: got %0d/%0d want 0/0", err_count, frame_count);
    end
    tick();
    reset_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_seek_drop();
    test_early_sof();
    test_missing_sof();
    test_stall();
    test_random();
    test_clear_and_reset();
    sb_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
